// File: rtl/nibble_seq_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// Provides the FSM state enum, the nibble width and a nibble-count helper.
package nibble_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int nibble_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit adder shared by the sequencer.
// Ports: x, y, cin in; sum[3:0], cout out.
module nibble_adder
  import nibble_seq_pkg::*;
(
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin
);

  assign {cout, sum} = {1'b0, x}
                     + {1'b0, y}
                     + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_add_sequencer.sv
// Multi-cycle WIDTH-bit adder: one 4-bit adder walked LSB nibble first.
// Ports: clk, rst_n, start, a, b, cin, [sub] in; busy, done, sum, cout out.
// Define NIBBLE_SEQ_SUB_EN to add the sub port (a - b via ~b + 1).
module nibble_add_sequencer
  import nibble_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = nibble_count(WIDTH);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_e               r_state;
  logic [IW-1:0]        r_idx;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_sum;
  logic                 r_carry;
  logic                 r_cout;

  logic [WIDTH-1:0]     w_b_in;
  logic                 w_c_in;
  logic [NIBBLE_W-1:0]  w_x;
  logic [NIBBLE_W-1:0]  w_y;
  logic [NIBBLE_W-1:0]  w_s;
  logic                 w_c;

`ifdef NIBBLE_SEQ_SUB_EN
  // Subtract folds into the add path: invert b, force carry-in.
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub | cin;
`else
  assign w_b_in = b;
  assign w_c_in = cin;
`endif

  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int k = 0; k < N; k++) begin
      if (r_idx == IW'(k)) begin
        w_x = r_a[k*NIBBLE_W +: NIBBLE_W];
        w_y = r_b[k*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  nibble_adder u_add (
    .sum  (w_s),
    .cout (w_c),
    .x    (w_x),
    .y    (w_y),
    .cin  (r_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_c_in;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < N; k++) begin
            if (r_idx == IW'(k)) begin
              r_sum[k*NIBBLE_W +: NIBBLE_W] <= w_s;
            end
          end
          r_carry <= w_c;
          if (r_idx == LAST) begin
            r_cout  <= w_c;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
